// File: rtl/pll_reset_seq_pkg.sv
// rtl/pll_reset_seq_pkg.sv - shared state encodings and timer sizing for the PLL reset sequencer
//
// Purpose: state enum shared by the sequencer and any debug/LED decode of state_o,
// plus the helper that sizes the single qualification/hold timer.
// Ports: none (package).

package pll_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_STAB = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    // One timer serves both STAB and HOLD, so it must hold the larger terminal count.
    function automatic int timer_width(input int stable_cycles, input int hold_cycles);
        int max_cycles;
        max_cycles = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync2.sv
// rtl/pll_reset_seq_sync2.sv - two-flop synchroniser for a single asynchronous level
//
// Purpose: brings an asynchronous level (PLL LOCK) into the clk domain.
// Ports:
//   clk  in  1  destination clock
//   rst  in  1  synchronous active-high reset, clears both flops
//   d_i  in  1  asynchronous input level
//   q_o  out 1  synchronised level, two clk edges of latency

module pll_reset_seq_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - holds system reset until PLL lock is qualified, re-asserts on lock loss
//
// Purpose: consumes PLL LOCK in the PLL output clock domain and produces a clean synchronous
// reset. Reset is released only after lock has stayed high for STABLE_CYCLES plus HOLD_CYCLES;
// any loss of lock after release re-asserts reset and is counted / flagged for debug.
// Ports:
//   clk              in  1      PLL output clock
//   rst              in  1      synchronous active-high reset
//   lock_in          in  1      PLL LOCK, asynchronous to clk
//   clear_sticky     in  1      single-cycle pulse, clears lock_lost_sticky
//   sys_rst          out 1      synchronous active-high reset to downstream logic
//   sys_ready        out 1      registered inverse of sys_rst
//   lock_loss_cnt    out CNT_W  saturating count of lock losses while running
//   lock_lost_sticky out 1      set on any lock loss while running
//   state_o          out 2      current sequencer state

module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int STABLE_CYCLES = 172000,
    parameter int HOLD_CYCLES   = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock_in,
    input  logic             clear_sticky,
    output logic             sys_rst,
    output logic             sys_ready,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic             lock_lost_sticky,
    output logic [1:0]       state_o
);

    localparam int TMR_W = timer_width(STABLE_CYCLES, HOLD_CYCLES);
    localparam logic [TMR_W-1:0] STAB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);

    logic             lock_s;
    state_e           state_q;
    logic [TMR_W-1:0] timer_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sticky_q;
    logic             sys_rst_q;
    logic             sys_ready_q;

    pll_reset_seq_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (lock_in),
        .q_o (lock_s)
    );

    // sys_rst/sys_ready default to "in reset" every edge and are only driven low
    // on edges whose next state is RUN, so they track state_q with no extra delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            timer_q     <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            sys_rst_q   <= 1'b1;
            sys_ready_q <= 1'b0;
        end else begin
            sys_rst_q   <= 1'b1;
            sys_ready_q <= 1'b0;

            // A loss event later in this block overrides the clear.
            if (clear_sticky) begin
                sticky_q <= 1'b0;
            end

            case (state_q)
                ST_WAIT: begin
                    if (lock_s) begin
                        state_q <= ST_STAB;
                        timer_q <= '0;
                    end
                end
                ST_STAB: begin
                    if (!lock_s) begin
                        state_q <= ST_WAIT;
                        timer_q <= '0;
                    end else if (timer_q == STAB_LAST) begin
                        state_q <= ST_HOLD;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        state_q <= ST_WAIT;
                        timer_q <= '0;
                    end else if (timer_q == HOLD_LAST) begin
                        state_q     <= ST_RUN;
                        sys_rst_q   <= 1'b0;
                        sys_ready_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_q  <= ST_WAIT;
                        timer_q  <= '0;
                        sticky_q <= 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        sys_rst_q   <= 1'b0;
                        sys_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_WAIT;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign sys_rst          = sys_rst_q;
    assign sys_ready        = sys_ready_q;
    assign lock_loss_cnt    = cnt_q;
    assign lock_lost_sticky = sticky_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - scoreboard bench for pll_reset_seq with a run-length reference model

module tb_pll_reset_seq;

    localparam int S     = 4;
    localparam int H     = 3;
    localparam int CW    = 2;
    localparam int RUN_C = S + H + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lock_in = 1'b0;
    logic          clear_sticky = 1'b0;
    logic          sys_rst;
    logic          sys_ready;
    logic [CW-1:0] lock_loss_cnt;
    logic          lock_lost_sticky;
    logic [1:0]    state_o;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .STABLE_CYCLES (S),
        .HOLD_CYCLES   (H),
        .CNT_W         (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lock_in          (lock_in),
        .clear_sticky     (clear_sticky),
        .sys_rst          (sys_rst),
        .sys_ready        (sys_ready),
        .lock_loss_cnt    (lock_loss_cnt),
        .lock_lost_sticky (lock_lost_sticky),
        .state_o          (state_o)
    );

    typedef struct packed {
        logic [1:0]    st;
        logic [CW-1:0] cnt;
        logic          sticky;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: lock_s is lock_in delayed two edges; the state follows from how many
    // consecutive edges the sequencer has seen lock_s high.
    logic [1:0] m_pipe   = 2'b00;
    int         m_run    = 0;
    int         m_cnt    = 0;
    logic       m_sticky = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model(input logic r, input logic l, input logic c);
        logic ls;
        logic loss;
        exp_t e;
        if (r) begin
            m_pipe   = 2'b00;
            m_run    = 0;
            m_cnt    = 0;
            m_sticky = 1'b0;
        end else begin
            ls     = m_pipe[1];
            m_pipe = {m_pipe[0], l};
            loss   = !ls && (m_run >= RUN_C);
            m_run  = ls ? ((m_run < RUN_C) ? m_run + 1 : RUN_C) : 0;
            if (loss) begin
                m_sticky = 1'b1;
                if (m_cnt < CMAX) m_cnt++;
            end else if (c) begin
                m_sticky = 1'b0;
            end
        end
        if (m_run == 0)      e.st = 2'd0;
        else if (m_run <= S) e.st = 2'd1;
        else if (m_run < RUN_C) e.st = 2'd2;
        else                 e.st = 2'd3;
        e.cnt    = CW'(m_cnt);
        e.sticky = m_sticky;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic l, input logic c);
        rst          = r;
        lock_in      = l;
        clear_sticky = c;
        @(posedge clk);
        model(r, l, c);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_state", 32'(state_o), 32'(e.st));
            chk("sb_sys_rst", 32'(sys_rst), 32'(e.st != 2'd3));
            chk("sb_sys_ready", 32'(sys_ready), 32'(e.st == 2'd3));
            chk("sb_cnt", 32'(lock_loss_cnt), 32'(e.cnt));
            chk("sb_sticky", 32'(lock_lost_sticky), 32'(e.sticky));
        end
    end

    initial begin
        // Reset with lock already high.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("reset_state", 32'(state_o), 0);
        chk("reset_sys_rst", 32'(sys_rst), 1);
        chk("reset_sys_ready", 32'(sys_ready), 0);
        chk("reset_cnt", 32'(lock_loss_cnt), 0);
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, 1'b0);
        chk("edge9_sys_rst", 32'(sys_rst), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("edge10_sys_rst", 32'(sys_rst), 0);
        chk("edge10_sys_ready", 32'(sys_ready), 1);
        chk("edge10_state", 32'(state_o), 3);

        // One-cycle lock drop in RUN.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("loss_edge2_sys_rst", 32'(sys_rst), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("loss_edge3_sys_rst", 32'(sys_rst), 1);
        chk("loss_cnt", 32'(lock_loss_cnt), 1);
        chk("loss_sticky", 32'(lock_lost_sticky), 1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
        chk("requal_edge9_sys_rst", 32'(sys_rst), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("requal_edge10_ready", 32'(sys_ready), 1);

        // Glitch while in STAB with timer=2.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("stab_t2_state", 32'(state_o), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("stab_glitch_state", 32'(state_o), 0);
        chk("stab_glitch_cnt", 32'(lock_loss_cnt), 0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
        chk("stab_requal_sys_rst", 32'(sys_rst), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("stab_requal_ready", 32'(sys_ready), 1);

        // Four losses saturate the 2-bit counter, a fifth leaves it there.
        for (int n = 0; n < 4; n++) begin
            step(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        end
        chk("sat_cnt", 32'(lock_loss_cnt), 3);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("sat_cnt_again", 32'(lock_loss_cnt), 3);
        chk("sat_state", 32'(state_o), 0);

        // Clear on the same edge as a loss: set wins; clear alone clears.
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("clr_loss_sticky", 32'(lock_lost_sticky), 1);
        step(1'b0, 1'b1, 1'b1);
        chk("clr_alone_sticky", 32'(lock_lost_sticky), 0);
        chk("clr_alone_cnt", 32'(lock_loss_cnt), 3);

        // rst while in HOLD.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
        chk("hold_state", 32'(state_o), 2);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_hold_state", 32'(state_o), 0);
        chk("rst_hold_sys_rst", 32'(sys_rst), 1);

        // rst while in RUN with a nonzero counter and sticky.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        chk("pre_rst_run_state", 32'(state_o), 3);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_run_state", 32'(state_o), 0);
        chk("rst_run_sys_rst", 32'(sys_rst), 1);
        chk("rst_run_cnt", 32'(lock_loss_cnt), 0);
        chk("rst_run_sticky", 32'(lock_lost_sticky), 0);

        // Randomised lock segments with occasional clear and rare reset.
        for (int n = 0; n < 80; n++) begin
            int hi;
            int lo;
            hi = $urandom_range(0, 20);
            lo = $urandom_range(1, 3);
            for (int i = 0; i < hi; i++)
                step(1'b0, 1'b1, ($urandom_range(0, 7) == 0));
            for (int i = 0; i < lo; i++)
                step(($urandom_range(0, 99) == 0), 1'b0, ($urandom_range(0, 7) == 0));
        end

        step(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
